// File: rtl/vga_pkg.sv
// Shared display-path constants: default 800x600@72 Hz raster timing,
// grid-mapper geometry and the common position type.
package vga_pkg;

    localparam int POS_W   = 11;
    localparam int POS_MAX = (1 << POS_W) - 1;

    typedef logic [POS_W-1:0] pos_t;

    // 800x600@72 Hz from a 50 MHz pixel clock
    localparam int   DEF_H_VIS  = 800;
    localparam int   DEF_H_FP   = 56;
    localparam int   DEF_H_SYNC = 120;
    localparam int   DEF_H_BP   = 64;
    localparam int   DEF_V_VIS  = 600;
    localparam int   DEF_V_FP   = 37;
    localparam int   DEF_V_SYNC = 6;
    localparam int   DEF_V_BP   = 23;
    localparam logic DEF_H_POL  = 1'b1;
    localparam logic DEF_V_POL  = 1'b1;
    localparam int   DEF_PIPE_DLY = 2;

    localparam int GRID_ORG_X  = 112;
    localparam int GRID_ORG_Y  = 39;
    localparam int GRID_CELL_W = 32;
    localparam int GRID_CELL_H = 17;
    localparam int GRID_COLS   = 20;
    localparam int GRID_ROWS   = 20;

    // Bundle that travels through the delay line to the VGA pins
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank_n;
    } sync_t;

    function automatic logic in_span(pos_t p, pos_t lo, pos_t hi);
        return (p >= lo) && (p < hi);
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Enabled shift register that lines up sync/blank with the colour lookup;
// reset preloads every stage so a reset also flushes the line.
module vga_sync_delay #(
    parameter int               WIDTH = 3,
    parameter int               DEPTH = 2,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    // NOTE: this array is only a few flops deep, so every stage is reset;
    // leaving it unreset would emit stale syncs right after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= INIT;
        end else if (en) begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running pixel/line counters, position decodes and
// sync/blank delayed to meet the colour data coming out of the grid RAM.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_VIS    = DEF_H_VIS,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_VIS    = DEF_V_VIS,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic H_POL    = DEF_H_POL,
    parameter logic V_POL    = DEF_V_POL,
    parameter int   PIPE_DLY = DEF_PIPE_DLY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic             active,
    output logic             line_start,
    output logic             frame_start,
    output logic             hsync,
    output logic             vsync,
    output logic             blank_n
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > POS_MAX || V_TOTAL > POS_MAX) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 11-bit position range");
    end
    if (PIPE_DLY < 1 || PIPE_DLY > 8) begin : g_bad_dly
        $error("vga_timing_gen: PIPE_DLY must be within 1..8");
    end

    localparam pos_t H_LAST     = pos_t'(H_TOTAL - 1);
    localparam pos_t V_LAST     = pos_t'(V_TOTAL - 1);
    localparam pos_t H_VIS_END  = pos_t'(H_VIS);
    localparam pos_t V_VIS_END  = pos_t'(V_VIS);
    localparam pos_t H_SYNC_ON  = pos_t'(H_VIS + H_FP);
    localparam pos_t H_SYNC_OFF = pos_t'(H_VIS + H_FP + H_SYNC);
    localparam pos_t V_SYNC_ON  = pos_t'(V_VIS + V_FP);
    localparam pos_t V_SYNC_OFF = pos_t'(V_VIS + V_FP + V_SYNC);

    localparam sync_t RST_SYNC = '{hsync: ~H_POL, vsync: ~V_POL, blank_n: 1'b0};

    sync_t raw;
    sync_t dly;

    // NOTE: registered state uses <= so every flop samples the pre-edge
    // values; blocking = here would chain pos_x into pos_y within one edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_x <= '0;
            pos_y <= '0;
        end else if (en) begin
            if (pos_x == H_LAST) begin
                pos_x <= '0;
                pos_y <= (pos_y == V_LAST) ? '0 : pos_y + 1'b1;
            end else begin
                pos_x <= pos_x + 1'b1;
            end
        end
    end

    // NOTE: raw gets a full default before any conditional logic so no
    // path through this block can leave a bit unassigned and infer a latch.
    always_comb begin
        raw         = RST_SYNC;
        active      = (pos_x < H_VIS_END) && (pos_y < V_VIS_END);
        line_start  = (pos_x == '0);
        frame_start = (pos_x == '0) && (pos_y == '0);
        raw.hsync   = in_span(pos_x, H_SYNC_ON, H_SYNC_OFF) ? H_POL : ~H_POL;
        raw.vsync   = in_span(pos_y, V_SYNC_ON, V_SYNC_OFF) ? V_POL : ~V_POL;
        raw.blank_n = active;
    end

    vga_sync_delay #(
        .WIDTH ($bits(sync_t)),
        .DEPTH (PIPE_DLY),
        .INIT  (RST_SYNC)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .d     (raw),
        .q     (dly)
    );

    assign hsync   = dly.hsync;
    assign vsync   = dly.vsync;
    assign blank_n = dly.blank_n;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 800x600 instance and a tiny
// active-low PIPE_DLY=1 instance, scoreboarded cycle by cycle plus directed checks.
module tb_vga_timing_gen;

    typedef struct {
        int h_vis, h_fp, h_sync, h_bp;
        int v_vis, v_fp, v_sync, v_bp;
        bit h_pol, v_pol;
        int dly;
    } cfg_t;

    typedef struct {
        int       x, y;
        bit [7:0] hs_p, vs_p, ac_p;
    } mdl_t;

    typedef struct packed {
        logic [10:0] x, y;
        logic act, ls, fs, hs, vs, bn;
    } exp_t;

    localparam cfg_t C0 = '{800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1, 2};
    localparam cfg_t C1 = '{8, 2, 3, 2, 4, 1, 2, 1, 1'b0, 1'b0, 1};

    logic clk = 1'b0;
    logic en0 = 1'b0, en1 = 1'b0, rst_n0 = 1'b0, rst_n1 = 1'b0;
    logic [10:0] pos_x0, pos_y0, pos_x1, pos_y1;
    logic active0, line_start0, frame_start0, hsync0, vsync0, blank_n0;
    logic active1, line_start1, frame_start1, hsync1, vsync1, blank_n1;

    int checks = 0;
    int failures = 0;
    exp_t q0[$], q1[$];
    mdl_t m0, m1;

    int cyc = 0;
    int ls_cnt0, hs_cnt0, bn_cnt0, fs_cnt1, vs_cnt1, bn_cnt1;
    int t856, t976, t10, lag_rise0, lag_fall0, lag_hs1;
    bit hs0_prev, hs1_prev;

    always #5 clk = ~clk;

    vga_timing_gen u_dut0 (
        .clk(clk), .rst_n(rst_n0), .en(en0),
        .pos_x(pos_x0), .pos_y(pos_y0), .active(active0),
        .line_start(line_start0), .frame_start(frame_start0),
        .hsync(hsync0), .vsync(vsync0), .blank_n(blank_n0)
    );

    vga_timing_gen #(
        .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(1'b0), .V_POL(1'b0), .PIPE_DLY(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n1), .en(en1),
        .pos_x(pos_x1), .pos_y(pos_y1), .active(active1),
        .line_start(line_start1), .frame_start(frame_start1),
        .hsync(hsync1), .vsync(vsync1), .blank_n(blank_n1)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic mdl_t mdl_step(mdl_t m, cfg_t c, bit rst_n, bit en);
        int ht = c.h_vis + c.h_fp + c.h_sync + c.h_bp;
        int vt = c.v_vis + c.v_fp + c.v_sync + c.v_bp;
        if (!rst_n) begin
            m.x = 0; m.y = 0;
            m.hs_p = '0; m.vs_p = '0; m.ac_p = '0;
        end else if (en) begin
            m.hs_p = {m.hs_p[6:0], (m.x >= c.h_vis + c.h_fp) && (m.x < c.h_vis + c.h_fp + c.h_sync)};
            m.vs_p = {m.vs_p[6:0], (m.y >= c.v_vis + c.v_fp) && (m.y < c.v_vis + c.v_fp + c.v_sync)};
            m.ac_p = {m.ac_p[6:0], (m.x < c.h_vis) && (m.y < c.v_vis)};
            if (m.x == ht - 1) begin
                m.x = 0;
                m.y = (m.y == vt - 1) ? 0 : m.y + 1;
            end else begin
                m.x = m.x + 1;
            end
        end
        return m;
    endfunction

    function automatic exp_t mdl_out(mdl_t m, cfg_t c);
        exp_t e;
        e.x  = 11'(m.x);
        e.y  = 11'(m.y);
        e.act = (m.x < c.h_vis) && (m.y < c.v_vis);
        e.ls = (m.x == 0);
        e.fs = (m.x == 0) && (m.y == 0);
        e.hs = m.hs_p[c.dly-1] ? c.h_pol : !c.h_pol;
        e.vs = m.vs_p[c.dly-1] ? c.v_pol : !c.v_pol;
        e.bn = m.ac_p[c.dly-1];
        return e;
    endfunction

    // One clock: drive inputs at the falling edge, queue the post-edge
    // expectation, and return at the next falling edge.
    task automatic step(bit e0, bit e1, bit r0, bit r1);
        en0 = e0; en1 = e1; rst_n0 = r0; rst_n1 = r1;
        m0 = mdl_step(m0, C0, r0, e0);
        m1 = mdl_step(m1, C1, r1, e1);
        q0.push_back(mdl_out(m0, C0));
        q1.push_back(mdl_out(m1, C1));
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: pops one expectation per DUT each cycle, and gathers pulse
    // counts and edge timing for the directed checks.
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("dut0_out", 32'({pos_x0, pos_y0, active0, line_start0, frame_start0,
                                   hsync0, vsync0, blank_n0}), 32'(e));
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("dut1_out", 32'({pos_x1, pos_y1, active1, line_start1, frame_start1,
                                   hsync1, vsync1, blank_n1}), 32'(e));
        end
        ls_cnt0 += int'(line_start0 === 1'b1);
        hs_cnt0 += int'(hsync0 === 1'b1);
        bn_cnt0 += int'(blank_n0 === 1'b1);
        fs_cnt1 += int'(frame_start1 === 1'b1);
        vs_cnt1 += int'(vsync1 === 1'b0);
        bn_cnt1 += int'(blank_n1 === 1'b1);
        if (pos_x0 === 11'd856) t856 = cyc;
        if (pos_x0 === 11'd976) t976 = cyc;
        if (pos_x1 === 11'd10)  t10  = cyc;
        if (hsync0 === 1'b1 && !hs0_prev) lag_rise0 = cyc - t856;
        if (hsync0 === 1'b0 && hs0_prev)  lag_fall0 = cyc - t976;
        if (hsync1 === 1'b0 && hs1_prev)  lag_hs1   = cyc - t10;
        hs0_prev = (hsync0 === 1'b1);
        hs1_prev = (hsync1 === 1'b1);
    end

    initial begin
        m0 = '{0, 0, '0, '0, '0};
        m1 = '{0, 0, '0, '0, '0};
        lag_rise0 = -1; lag_fall0 = -1; lag_hs1 = -1;
        @(negedge clk);

        // Reset is honoured whether or not EN is high
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        check("rst_active0", 32'(active0), 32'd1);
        check("rst_line_start0", 32'(line_start0), 32'd1);
        check("rst_frame_start0", 32'(frame_start0), 32'd1);
        check("rst_hsync0", 32'(hsync0), 32'd0);
        check("rst_vsync0", 32'(vsync0), 32'd0);
        check("rst_blank_n0", 32'(blank_n0), 32'd0);
        check("rst_hsync1_idle_high", 32'(hsync1), 32'd1);
        check("rst_vsync1_idle_high", 32'(vsync1), 32'd1);

        // Two full default lines plus 10 pixels with EN held high
        for (int i = 1; i <= 2090; i++) begin
            if (i == 1) begin
                ls_cnt0 = 0; hs_cnt0 = 0; bn_cnt0 = 0;
            end
            if (i == 241) begin
                fs_cnt1 = 0; vs_cnt1 = 0; bn_cnt1 = 0;
            end
            step(1, 1, 1, 1);
            if (i == 360) begin
                check("dut1_frame_start_per_frame", 32'(fs_cnt1), 32'd1);
                check("dut1_vsync_low_cycles", 32'(vs_cnt1), 32'd30);
                check("dut1_blank_n_high_cycles", 32'(bn_cnt1), 32'd32);
                check("dut1_hsync_lag", 32'(lag_hs1), 32'd1);
            end
            if (i == 1040) begin
                check("dut0_line_start_per_line", 32'(ls_cnt0), 32'd1);
                check("dut0_hsync_high_cycles", 32'(hs_cnt0), 32'd120);
                check("dut0_blank_n_high_cycles", 32'(bn_cnt0), 32'd800);
                check("dut0_hsync_rise_lag", 32'(lag_rise0), 32'd2);
                check("dut0_hsync_fall_lag", 32'(lag_fall0), 32'd2);
                check("dut0_wrap_pos_x", 32'(pos_x0), 32'd0);
                check("dut0_wrap_pos_y", 32'(pos_y0), 32'd1);
            end
        end
        check("dut0_pos_x_2090", 32'(pos_x0), 32'd10);
        check("dut0_pos_y_2090", 32'(pos_y0), 32'd2);
        check("dut1_pos_x_2090", 32'(pos_x1), 32'd5);
        check("dut1_pos_y_2090", 32'(pos_y1), 32'd3);

        // EN toggling: only the 20 enabled edges advance anything
        for (int i = 0; i < 40; i++) step(i % 2 == 0, i % 2 == 0, 1, 1);
        check("dut0_pos_x_toggle", 32'(pos_x0), 32'd30);
        check("dut1_pos_x_toggle", 32'(pos_x1), 32'd10);
        check("dut1_pos_y_toggle", 32'(pos_y1), 32'd4);

        // Walk DUT0 to (500,2), then a one-cycle mid-line reset
        for (int i = 0; i < 470; i++) step(1, 1, 1, 1);
        check("dut0_pre_rst_pos_x", 32'(pos_x0), 32'd500);
        step(1, 0, 0, 0);
        check("midrst_pos_x0", 32'(pos_x0), 32'd0);
        check("midrst_pos_y0", 32'(pos_y0), 32'd0);
        check("midrst_hsync0", 32'(hsync0), 32'd0);
        check("midrst_vsync0", 32'(vsync0), 32'd0);
        check("midrst_blank_n0", 32'(blank_n0), 32'd0);
        check("midrst_blank_n1", 32'(blank_n1), 32'd0);
        step(1, 1, 1, 1);
        check("post_rst_blank_n0_edge1", 32'(blank_n0), 32'd0);
        check("post_rst_blank_n1_edge1", 32'(blank_n1), 32'd1);
        step(0, 0, 1, 1);
        check("post_rst_blank_n0_hold", 32'(blank_n0), 32'd0);
        step(1, 1, 1, 1);
        check("post_rst_blank_n0_edge2", 32'(blank_n0), 32'd1);

        for (int i = 0; i < 200; i++) step(1, 1, 1, 1);
        @(negedge clk);
        check("scoreboard0_drained", 32'(q0.size()), 32'd0);
        check("scoreboard1_drained", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
